// File: rtl/carry_select_rca_block.sv
// Ripple-carry building block: an N-bit chain of full adders.
// Used directly for the lowest block and twice (cin=0 / cin=1) for every higher one.
module rca_block #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] chain_s;

  assign chain_s[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]         = a[i] ^ b[i] ^ chain_s[i];
    assign chain_s[i + 1] = (a[i] & b[i]) | (chain_s[i] & (a[i] ^ b[i]));
  end

  assign co = chain_s[N];

endmodule

// File: rtl/carry_select.sv
// Carry-select adder with registered outputs: {cout,s} <= x + y + carry, latency 1.
// Block 0 ripples from carry; each higher block precomputes both carry cases and muxes.
module carry_select #(
  parameter int WIDTH = 4,
  parameter int BLK   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             carry,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;

  // Carries stay in per-block scopes so the chain is not one self-referencing vector.
  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int NB = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

    logic [NB-1:0] bsum_s;
    logic          co_s;

    if (k == 0) begin : g_ripple
      rca_block #(.N(NB)) u_rca (
        .a   (x[LO +: NB]),
        .b   (y[LO +: NB]),
        .ci  (carry),
        .sum (bsum_s),
        .co  (co_s)
      );
    end else begin : g_select
      logic [NB-1:0] sum0_s;
      logic [NB-1:0] sum1_s;
      logic          co0_s;
      logic          co1_s;
      logic          sel_s;

      assign sel_s = g_blk[k - 1].co_s;

      rca_block #(.N(NB)) u_rca0 (
        .a   (x[LO +: NB]),
        .b   (y[LO +: NB]),
        .ci  (1'b0),
        .sum (sum0_s),
        .co  (co0_s)
      );

      rca_block #(.N(NB)) u_rca1 (
        .a   (x[LO +: NB]),
        .b   (y[LO +: NB]),
        .ci  (1'b1),
        .sum (sum1_s),
        .co  (co1_s)
      );

      assign bsum_s = sel_s ? sum1_s : sum0_s;
      assign co_s   = sel_s ? co1_s  : co0_s;
    end

    assign sum_s[LO +: NB] = bsum_s;
  end

  assign cout_s = g_blk[NBLK - 1].co_s;

  // Output register; reset overrides the incoming sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r    <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
    end else begin
      s_r    <= sum_s;
      cout_r <= cout_s;
    end
  end

  assign s    = s_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_carry_select.sv
// Directed and sweep bench for carry_select at 4/2, 5/2 and 8/3 configurations.
module tb_carry_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] x4 = 4'd0, y4 = 4'd0, s4;
  logic       c4 = 1'b0, co4;
  logic [4:0] x5 = 5'd0, y5 = 5'd0, s5;
  logic       c5 = 1'b0, co5;
  logic [7:0] x8 = 8'd0, y8 = 8'd0, s8;
  logic       c8 = 1'b0, co8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  carry_select #(.WIDTH(4), .BLK(2)) u_dut4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .carry(c4), .s(s4), .cout(co4));
  carry_select #(.WIDTH(5), .BLK(2)) u_dut5 (
    .clk(clk), .rst(rst), .x(x5), .y(y5), .carry(c5), .s(s5), .cout(co5));
  carry_select #(.WIDTH(8), .BLK(3)) u_dut8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .carry(c8), .s(s8), .cout(co8));

  // Hand-computed vectors: {x, y, carry} -> {cout, s}
  localparam logic [3:0] BX [3] = '{4'b0001, 4'b1001, 4'b0101};
  localparam logic [3:0] BY [3] = '{4'b0110, 4'b0010, 4'b0001};
  localparam logic       BC [3] = '{1'b0, 1'b1, 1'b1};
  localparam logic [4:0] BE [3] = '{5'b0_0111, 5'b0_1100, 5'b0_0111};

  localparam logic [3:0] XX [3] = '{4'b0111, 4'b0111, 4'b1101};
  localparam logic [3:0] XY [3] = '{4'b0010, 4'b0001, 4'b0010};
  localparam logic       XC [3] = '{1'b1, 1'b0, 1'b0};
  localparam logic [4:0] XE [3] = '{5'b0_1010, 5'b0_1000, 5'b0_1111};

  localparam logic [3:0] OX [3] = '{4'b1111, 4'b1111, 4'b0000};
  localparam logic [3:0] OY [3] = '{4'b0001, 4'b1111, 4'b0000};
  localparam logic       OC [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [4:0] OE [3] = '{5'b1_0000, 5'b1_1111, 5'b0_0000};

  task automatic test_reset();
    rst = 1'b1;
    x4 = 4'b1111; y4 = 4'b1111; c4 = 1'b1;
    x5 = 5'h1f;   y5 = 5'h1f;   c5 = 1'b1;
    x8 = 8'hff;   y8 = 8'hff;   c8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== 5'b0_0000) begin
        failures++;
        $display("FAIL reset4 cyc%0d: got %b expected 00000", i, {co4, s4});
      end
      checks++;
      if ({co5, s5} !== 6'd0 || {co8, s8} !== 9'd0) begin
        failures++;
        $display("FAIL reset_wide cyc%0d: got %h/%h expected 0/0", i, {co5, s5}, {co8, s8});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      x4 = BX[i]; y4 = BY[i]; c4 = BC[i];
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== BE[i]) begin
        failures++;
        $display("FAIL basic%0d: got %b expected %b", i, {co4, s4}, BE[i]);
      end
    end
  endtask

  task automatic test_cross_block();
    for (int i = 0; i < 3; i++) begin
      x4 = XX[i]; y4 = XY[i]; c4 = XC[i];
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== XE[i]) begin
        failures++;
        $display("FAIL cross%0d: got %b expected %b", i, {co4, s4}, XE[i]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      x4 = OX[i]; y4 = OY[i]; c4 = OC[i];
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== OE[i]) begin
        failures++;
        $display("FAIL overflow%0d: got %b expected %b", i, {co4, s4}, OE[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    for (int i = 0; i < 16; i++) begin
      x4 = 4'((i * 7 + 3) % 16);
      y4 = 4'((i * 11 + 5) % 16);
      c4 = i[0];
      exp = 5'(x4) + 5'(y4) + 5'(c4);
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== exp) begin
        failures++;
        $display("FAIL b2b%0d: got %b expected %b", i, {co4, s4}, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    x4 = 4'b0011; y4 = 4'b0100; c4 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({co4, s4} !== 5'b0_0111) begin
      failures++;
      $display("FAIL mid_before: got %b expected 00111", {co4, s4});
    end
    rst = 1'b1;
    x4 = 4'b1111; y4 = 4'b1111; c4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({co4, s4} !== 5'b0_0000) begin
      failures++;
      $display("FAIL mid_reset: got %b expected 00000", {co4, s4});
    end
    rst = 1'b0;
    x4 = 4'b1001; y4 = 4'b0110; c4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({co4, s4} !== 5'b1_0000) begin
      failures++;
      $display("FAIL mid_after: got %b expected 10000", {co4, s4});
    end
  endtask

  task automatic test_sweep4();
    logic [4:0] exp;
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      x4 = v[3:0]; y4 = v[7:4]; c4 = v[8];
      exp = 5'(x4) + 5'(y4) + 5'(c4);
      @(posedge clk); #1;
      checks++;
      if ({co4, s4} !== exp) begin
        failures++;
        $display("FAIL sweep4 x=%h y=%h c=%b: got %b expected %b", x4, y4, c4, {co4, s4}, exp);
      end
    end
  endtask

  task automatic test_sweep5();
    logic [5:0]  exp;
    logic [10:0] v;
    for (int i = 0; i < 2048; i++) begin
      v = 11'(i);
      x5 = v[4:0]; y5 = v[9:5]; c5 = v[10];
      exp = 6'(x5) + 6'(y5) + 6'(c5);
      @(posedge clk); #1;
      checks++;
      if ({co5, s5} !== exp) begin
        failures++;
        $display("FAIL sweep5 x=%h y=%h c=%b: got %h expected %h", x5, y5, c5, {co5, s5}, exp);
      end
    end
  endtask

  task automatic test_sweep8();
    logic [8:0] exp;
    for (int i = 0; i < 1024; i++) begin
      if (i < 4) begin
        x8 = (i < 2) ? 8'hff : 8'h00;
        y8 = (i == 0) ? 8'hff : ((i == 1) ? 8'h00 : 8'h00);
        c8 = (i == 1 || i == 0) ? 1'b1 : 1'b0;
      end else if (i < 12) begin
        x8 = 8'(8'hff >> (i - 4));
        y8 = 8'h01;
        c8 = 1'b0;
      end else begin
        x8 = 8'($urandom_range(255, 0));
        y8 = 8'($urandom_range(255, 0));
        c8 = 1'($urandom_range(1, 0));
      end
      exp = 9'(x8) + 9'(y8) + 9'(c8);
      @(posedge clk); #1;
      checks++;
      if ({co8, s8} !== exp) begin
        failures++;
        $display("FAIL sweep8 x=%h y=%h c=%b: got %h expected %h", x8, y8, c8, {co8, s8}, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_cross_block();
    test_overflow();
    test_back_to_back();
    test_reset_midstream();
    test_sweep4();
    test_sweep5();
    test_sweep8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
